// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

    localparam int XLEN_PC = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN_PC-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_PC-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN_PC-1:0] align_pc(input logic [XLEN_PC-1:0] a);
        return a & ~XLEN_PC'(3);
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - synchronous fetch_entry_t FIFO with flush, used for prefetch queue and PC tags
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           wr_data,
    input  logic                   pop,
    output fetch_entry_t           rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, in-order imem fetch, prefetch queue and redirect flush; IFU_PERF_CNT_EN adds perf counters
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0] perf_fetched,
    output logic [63:0] perf_flushed
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] q_count;
    logic [CW-1:0] tag_count;
    logic [CW-1:0] outstanding;
    logic [CW:0]   inflight;
    logic          q_full;
    logic          q_empty;
    logic          tag_full;
    logic          tag_empty;
    logic          credit_ok;
    logic          req_fire;
    logic          rsp_keep;
    logic          rsp_drop;
    logic          id_fire;
    fetch_entry_t  tag_wr;
    fetch_entry_t  tag_head;
    fetch_entry_t  q_wr;
    fetch_entry_t  q_head;

    // Responses still owed to pre-redirect requests hold their credit until they drain.
    assign outstanding = tag_count + drop_cnt;
    assign inflight    = (CW+1)'(q_count) + (CW+1)'(outstanding);
    assign credit_ok   = (inflight < (CW+1)'(DEPTH)) && !q_full && !tag_full;

    assign imem_req_valid = !rst && !redirect_valid && credit_ok;
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = !rst && imem_rsp_valid && (redirect_valid || (drop_cnt != '0));
    assign rsp_keep = !rst && imem_rsp_valid && !redirect_valid && (drop_cnt == '0) && !tag_empty;

    assign id_valid = !rst && !redirect_valid && !q_empty;
    assign id_fire  = id_valid && id_ready;
    assign id_pc    = id_valid ? q_head.pc    : '0;
    assign id_instr = id_valid ? q_head.instr : '0;

    always_comb begin
        tag_wr       = '0;
        tag_wr.pc    = pc;
        tag_wr.instr = NOP_INSTR;
        q_wr         = tag_head;
        q_wr.instr   = imem_rsp_data;
    end

    ifu_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect_valid),
        .push    (req_fire),
        .wr_data (tag_wr),
        .pop     (rsp_keep),
        .rd_data (tag_head),
        .full    (tag_full),
        .empty   (tag_empty),
        .count   (tag_count)
    );

    ifu_fifo #(.DEPTH(DEPTH)) u_prefetch_q (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect_valid),
        .push    (rsp_keep),
        .wr_data (q_wr),
        .pop     (id_fire),
        .rd_data (q_head),
        .full    (q_full),
        .empty   (q_empty),
        .count   (q_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            pc       <= align_pc(redirect_pc);
            // A response landing in the redirect cycle belongs to the oldest outstanding fetch.
            drop_cnt <= outstanding - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc <= pc + 32'd4;
            end
            if (imem_rsp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= perf_fetched + 64'(id_fire);
            perf_flushed <= perf_flushed + (redirect_valid ? 64'(q_count) : 64'd0) + 64'(rsp_drop);
        end
    end
`endif

endmodule
